// File: rtl/inst_fetch_pkg.sv
// -----------------------------------------------------------------------------
// inst_fetch_pkg
// Shared definitions for the instruction-fetch stage: FSM state encoding,
// AXI4-Lite response/protection constants, the NOP word substituted on a
// faulting fetch, and a word-alignment helper.
// -----------------------------------------------------------------------------
package inst_fetch_pkg;

  typedef enum logic [1:0] {
    S_ADDR = 2'd0,  // AR channel active, waiting for arready
    S_DATA = 2'd1,  // R channel active, waiting for rvalid
    S_HOLD = 2'd2   // response parked while decode is stalled
  } fetch_state_e;

  localparam logic [1:0]  AXI_RESP_OKAY = 2'b00;
  localparam logic [2:0]  ARPROT_INST   = 3'b100;  // instruction, secure, unprivileged
  localparam logic [31:0] NOP_INST      = 32'h0000_0000;

  // PCs are always word aligned; low two bits are dropped on every load.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/inst_fetch_if.sv
// -----------------------------------------------------------------------------
// inst_fetch_if
// AXI4-Lite read-only channel pair (AR + R) used by the fetch stage.
//   master : fetch stage (drives araddr/arprot/arvalid/rready)
//   slave  : instruction memory (drives arready/rdata/rresp/rvalid)
// -----------------------------------------------------------------------------
interface inst_fetch_if;

  logic [31:0] araddr;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  modport master (
    output araddr, arprot, arvalid, rready,
    input  arready, rdata, rresp, rvalid
  );

  modport slave (
    input  araddr, arprot, arvalid, rready,
    output arready, rdata, rresp, rvalid
  );

endinterface

// File: rtl/inst_fetch.sv
// -----------------------------------------------------------------------------
// inst_fetch
// Instruction-fetch stage. Owns the PC, issues one AXI4-Lite read per
// instruction (at most one outstanding), and presents a registered
// inst_addr/inst_data/inst_valid triple to decode.
//
// Ports
//   clk       : clock, rising edge
//   rst       : asynchronous reset, active low
//   stall     : decode cannot accept; output triple holds
//   flush     : one-cycle redirect request (overrides stall)
//   flush_pc  : redirect target, sampled when flush=1
//   axi       : AXI4-Lite read master (AR + R channels)
//   inst_addr : address of the delivered instruction
//   inst_data : delivered instruction (NOP on a non-OKAY response)
//   inst_valid: delivered word is valid this cycle
//   fetch_err : one-cycle pulse with a word that came back non-OKAY
// -----------------------------------------------------------------------------
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stall,
  input  logic                flush,
  input  logic [31:0]         flush_pc,
  inst_fetch_if.master        axi,
  output logic [31:0]         inst_addr,
  output logic [31:0]         inst_data,
  output logic                inst_valid,
  output logic                fetch_err
);

  fetch_state_e state_reg;
  logic [31:0]  pc_reg;
  logic [31:0]  araddr_reg;
  logic         arvalid_reg;
  logic         rready_reg;
  logic         drop_reg;       // in-flight transaction belongs to a flushed path
  logic [33:0]  hold_buf_reg;   // {rresp, rdata} parked during a stall
  logic [31:0]  inst_addr_reg;
  logic [31:0]  inst_data_reg;
  logic         inst_valid_reg;
  logic         fetch_err_reg;

  logic [31:0]  pc_inc;
  logic [31:0]  flush_pc_al;
  logic [31:0]  dlv_data;
  logic [1:0]   dlv_resp;
  logic         dlv_ok;

  assign pc_inc      = pc_reg + 32'd4;
  assign flush_pc_al = word_align(flush_pc);

  // Word handed to decode comes straight from the R channel in S_DATA and
  // from the parked buffer in S_HOLD.
  assign dlv_data = (state_reg == S_HOLD) ? hold_buf_reg[31:0]  : axi.rdata;
  assign dlv_resp = (state_reg == S_HOLD) ? hold_buf_reg[33:32] : axi.rresp;
  assign dlv_ok   = (dlv_resp == AXI_RESP_OKAY);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg      <= S_ADDR;
      pc_reg         <= word_align(RESET_PC);
      araddr_reg     <= word_align(RESET_PC);
      arvalid_reg    <= 1'b0;
      rready_reg     <= 1'b0;
      drop_reg       <= 1'b0;
      hold_buf_reg   <= '0;
      inst_addr_reg  <= '0;
      inst_data_reg  <= '0;
      inst_valid_reg <= 1'b0;
      fetch_err_reg  <= 1'b0;
    end else begin
      fetch_err_reg <= 1'b0;
      // Valid drops unless a word is delivered below; stall alone freezes it.
      if (flush || !stall) begin
        inst_valid_reg <= 1'b0;
      end

      unique case (state_reg)
        S_ADDR: begin
          if (!arvalid_reg) begin
            // Only reached straight out of reset: launch the first request.
            // A flush here simply retargets it, nothing is in flight yet.
            arvalid_reg <= 1'b1;
            if (flush) begin
              pc_reg     <= flush_pc_al;
              araddr_reg <= flush_pc_al;
            end else begin
              araddr_reg <= pc_reg;
            end
          end else if (axi.arready) begin
            arvalid_reg <= 1'b0;
            rready_reg  <= 1'b1;
            state_reg   <= S_DATA;
            if (flush) begin
              pc_reg   <= flush_pc_al;
              drop_reg <= 1'b1;
            end
          end else if (flush) begin
            // Address must stay stable while pending; mark its data stale.
            pc_reg   <= flush_pc_al;
            drop_reg <= 1'b1;
          end
        end

        S_DATA: begin
          if (axi.rvalid) begin
            rready_reg <= 1'b0;
            if (flush) begin
              pc_reg      <= flush_pc_al;
              araddr_reg  <= flush_pc_al;
              arvalid_reg <= 1'b1;
              drop_reg    <= 1'b0;
              state_reg   <= S_ADDR;
            end else if (drop_reg) begin
              // pc already holds the redirect target.
              araddr_reg  <= pc_reg;
              arvalid_reg <= 1'b1;
              drop_reg    <= 1'b0;
              state_reg   <= S_ADDR;
            end else if (!stall) begin
              inst_addr_reg  <= pc_reg;
              inst_data_reg  <= dlv_ok ? dlv_data : NOP_INST;
              inst_valid_reg <= 1'b1;
              fetch_err_reg  <= !dlv_ok;
              pc_reg         <= pc_inc;
              araddr_reg     <= pc_inc;
              arvalid_reg    <= 1'b1;
              state_reg      <= S_ADDR;
            end else begin
              hold_buf_reg <= {axi.rresp, axi.rdata};
              state_reg    <= S_HOLD;
            end
          end else if (flush) begin
            pc_reg   <= flush_pc_al;
            drop_reg <= 1'b1;
          end
        end

        S_HOLD: begin
          if (flush) begin
            pc_reg      <= flush_pc_al;
            araddr_reg  <= flush_pc_al;
            arvalid_reg <= 1'b1;
            state_reg   <= S_ADDR;
          end else if (!stall) begin
            inst_addr_reg  <= pc_reg;
            inst_data_reg  <= dlv_ok ? dlv_data : NOP_INST;
            inst_valid_reg <= 1'b1;
            fetch_err_reg  <= !dlv_ok;
            pc_reg         <= pc_inc;
            araddr_reg     <= pc_inc;
            arvalid_reg    <= 1'b1;
            state_reg      <= S_ADDR;
          end
        end

        default: begin
          state_reg   <= S_ADDR;
          arvalid_reg <= 1'b0;
          rready_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign axi.araddr  = araddr_reg;
  assign axi.arprot  = ARPROT_INST;
  assign axi.arvalid = arvalid_reg;
  assign axi.rready  = rready_reg;

  assign inst_addr  = inst_addr_reg;
  assign inst_data  = inst_data_reg;
  assign inst_valid = inst_valid_reg;
  assign fetch_err  = fetch_err_reg;

endmodule

// File: tb/tb_inst_fetch.sv
// -----------------------------------------------------------------------------
// tb_inst_fetch
// Directed bench for inst_fetch. The memory side is driven cycle by cycle
// from a single initial block; expected values are written out by hand.
// -----------------------------------------------------------------------------
module tb_inst_fetch;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        flush;
  logic [31:0] flush_pc;
  logic [31:0] inst_addr;
  logic [31:0] inst_data;
  logic        inst_valid;
  logic        fetch_err;

  int checks = 0;
  int errors = 0;

  inst_fetch_if axi_if ();

  inst_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk       (clk),
    .rst       (rst),
    .stall     (stall),
    .flush     (flush),
    .flush_pc  (flush_pc),
    .axi       (axi_if),
    .inst_addr (inst_addr),
    .inst_data (inst_data),
    .inst_valid(inst_valid),
    .fetch_err (fetch_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_inst(input string tag, input logic v, input logic [31:0] a,
                            input logic [31:0] d);
    check({tag, ".valid"}, {31'd0, inst_valid}, {31'd0, v});
    check({tag, ".addr"},  inst_addr, a);
    check({tag, ".data"},  inst_data, d);
    $display("[%0t] %s: valid=%0b addr=%h data=%h err=%0b araddr=%h arvalid=%0b",
             $time, tag, inst_valid, inst_addr, inst_data, fetch_err,
             axi_if.araddr, axi_if.arvalid);
  endtask

  task automatic check_ar(input string tag, input logic v, input logic [31:0] a);
    check({tag, ".arvalid"}, {31'd0, axi_if.arvalid}, {31'd0, v});
    if (v) check({tag, ".araddr"}, axi_if.araddr, a);
  endtask

  initial begin
    rst = 1'b1;
    stall = 1'b0;
    flush = 1'b0;
    flush_pc = 32'h0;
    axi_if.arready = 1'b0;
    axi_if.rvalid  = 1'b0;
    axi_if.rdata   = 32'h0;
    axi_if.rresp   = 2'b00;
    #2 rst = 1'b0;
    step();
    step();

    // ---- reset state ----
    check_inst("reset", 1'b0, 32'h0, 32'h0);
    check("reset.arvalid", {31'd0, axi_if.arvalid}, 32'd0);
    check("reset.rready",  {31'd0, axi_if.rready},  32'd0);
    check("reset.fetch_err", {31'd0, fetch_err}, 32'd0);
    check("arprot", {29'd0, axi_if.arprot}, 32'd4);

    // ---- back-to-back fetches, word = addr ^ A5A5A5A5 ----
    rst = 1'b1;
    axi_if.arready = 1'b1;
    axi_if.rvalid  = 1'b1;
    axi_if.rdata   = 32'hA5A5_A5A5;
    step();
    check_ar("b2b.first_ar", 1'b1, 32'h0);
    step();
    check("b2b.rready", {31'd0, axi_if.rready}, 32'd1);
    check_ar("b2b.ar_low", 1'b0, 32'h0);
    step();
    check_inst("b2b.w0", 1'b1, 32'h0, 32'hA5A5_A5A5);
    check_ar("b2b.ar4", 1'b1, 32'h4);
    axi_if.rdata = 32'hA5A5_A5A1;
    step();
    check("b2b.gap0", {31'd0, inst_valid}, 32'd0);
    step();
    check_inst("b2b.w1", 1'b1, 32'h4, 32'hA5A5_A5A1);
    axi_if.rdata = 32'hA5A5_A5AD;
    step();
    check("b2b.gap1", {31'd0, inst_valid}, 32'd0);
    step();
    check_inst("b2b.w2", 1'b1, 32'h8, 32'hA5A5_A5AD);
    check_ar("b2b.arC", 1'b1, 32'hC);
    axi_if.arready = 1'b0;
    axi_if.rvalid  = 1'b0;

    // ---- asynchronous reset mid-transaction ----
    rst = 1'b0;
    #1;
    check_inst("midrst", 1'b0, 32'h0, 32'h0);
    check_ar("midrst.ar", 1'b0, 32'h0);
    step();
    rst = 1'b1;
    step();
    check_ar("rel.ar", 1'b1, 32'h0);

    // ---- arready held low 3 cycles ----
    for (int i = 0; i < 3; i++) begin
      step();
      check_ar("arwait", 1'b1, 32'h0);
    end
    axi_if.arready = 1'b1;
    step();
    check("arwait.rready", {31'd0, axi_if.rready}, 32'd1);
    axi_if.arready = 1'b0;
    axi_if.rvalid  = 1'b1;
    axi_if.rdata   = 32'h1357_9BDF;
    step();
    check_inst("arwait.done", 1'b1, 32'h0, 32'h1357_9BDF);
    axi_if.rvalid = 1'b0;

    // ---- error response at pc 0x4 ----
    axi_if.arready = 1'b1;
    step();
    axi_if.arready = 1'b0;
    axi_if.rvalid  = 1'b1;
    axi_if.rdata   = 32'hDEAD_BEEF;
    axi_if.rresp   = 2'b10;
    step();
    check_inst("slverr", 1'b1, 32'h4, 32'h0);
    check("slverr.fetch_err", {31'd0, fetch_err}, 32'd1);
    check_ar("slverr.next", 1'b1, 32'h8);
    axi_if.rvalid = 1'b0;
    axi_if.rresp  = 2'b00;
    step();
    check("slverr.err_pulse", {31'd0, fetch_err}, 32'd0);
    check("slverr.valid_drop", {31'd0, inst_valid}, 32'd0);

    // ---- stall with response at pc 0x8 ----
    axi_if.arready = 1'b1;
    step();
    axi_if.arready = 1'b0;
    stall = 1'b1;
    axi_if.rvalid = 1'b1;
    axi_if.rdata  = 32'h3421_0001;
    step();
    axi_if.rvalid = 1'b0;
    check_inst("stall.hold", 1'b0, 32'h4, 32'h0);
    check_ar("stall.no_ar", 1'b0, 32'h0);
    check("stall.rready", {31'd0, axi_if.rready}, 32'd0);
    step();
    check_inst("stall.hold2", 1'b0, 32'h4, 32'h0);
    check_ar("stall.no_ar2", 1'b0, 32'h0);
    stall = 1'b0;
    step();
    check_inst("stall.release", 1'b1, 32'h8, 32'h3421_0001);
    check_ar("stall.next", 1'b1, 32'hC);
    stall = 1'b1;
    step();
    check_inst("stall.freeze", 1'b1, 32'h8, 32'h3421_0001);
    stall = 1'b0;
    step();
    check("stall.drop", {31'd0, inst_valid}, 32'd0);

    // ---- flush in S_DATA before rvalid ----
    axi_if.arready = 1'b1;
    step();
    axi_if.arready = 1'b0;
    flush = 1'b1;
    flush_pc = 32'h0000_0100;
    step();
    flush = 1'b0;
    check("fdata.rready", {31'd0, axi_if.rready}, 32'd1);
    axi_if.rvalid = 1'b1;
    axi_if.rdata  = 32'hBAD0_BAD0;
    step();
    axi_if.rvalid = 1'b0;
    check("fdata.discard", {31'd0, inst_valid}, 32'd0);
    check_ar("fdata.new", 1'b1, 32'h100);

    // ---- flush coincident with rvalid, unaligned target ----
    axi_if.arready = 1'b1;
    step();
    axi_if.arready = 1'b0;
    axi_if.rvalid = 1'b1;
    flush = 1'b1;
    flush_pc = 32'h0000_0203;
    step();
    axi_if.rvalid = 1'b0;
    flush = 1'b0;
    check("fsim.discard", {31'd0, inst_valid}, 32'd0);
    check_ar("fsim.new", 1'b1, 32'h200);

    // ---- flush in S_ADDR while arready low ----
    flush = 1'b1;
    flush_pc = 32'h0000_0300;
    step();
    flush = 1'b0;
    check_ar("faddr.stable", 1'b1, 32'h200);
    step();
    check_ar("faddr.stable2", 1'b1, 32'h200);
    axi_if.arready = 1'b1;
    step();
    axi_if.arready = 1'b0;
    axi_if.rvalid = 1'b1;
    axi_if.rdata  = 32'h1111_1111;
    step();
    axi_if.rvalid = 1'b0;
    check("faddr.discard", {31'd0, inst_valid}, 32'd0);
    check_ar("faddr.new", 1'b1, 32'h300);
    axi_if.arready = 1'b1;
    step();
    axi_if.arready = 1'b0;
    axi_if.rvalid = 1'b1;
    axi_if.rdata  = 32'hCAFE_0300;
    step();
    axi_if.rvalid = 1'b0;
    check_inst("faddr.fetch", 1'b1, 32'h300, 32'hCAFE_0300);

    // ---- flush with arready same cycle, pc wrap at 2^32 ----
    flush = 1'b1;
    flush_pc = 32'hFFFF_FFFF;
    axi_if.arready = 1'b1;
    step();
    flush = 1'b0;
    axi_if.arready = 1'b0;
    axi_if.rvalid = 1'b1;
    axi_if.rdata  = 32'h2222_2222;
    step();
    axi_if.rvalid = 1'b0;
    check("wrap.discard", {31'd0, inst_valid}, 32'd0);
    check_ar("wrap.ar", 1'b1, 32'hFFFF_FFFC);
    axi_if.arready = 1'b1;
    step();
    axi_if.arready = 1'b0;
    axi_if.rvalid = 1'b1;
    axi_if.rdata  = 32'h1234_5678;
    step();
    axi_if.rvalid = 1'b0;
    check_inst("wrap.fetch", 1'b1, 32'hFFFF_FFFC, 32'h1234_5678);
    check_ar("wrap.next", 1'b1, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
